// File: rtl/vc_pkg.sv
// Shared types and constants for the victim cache sequencing controller.
package vc_pkg;

    localparam int NUM_WAYS = 8;
    localparam int TAG_W    = 44;
    localparam int IDX_W    = 6;
    localparam int OFF_W    = 6;
    localparam int PLRU_W   = 7;
    localparam int WAY_W    = 3;
    localparam int ADDR_W   = IDX_W + OFF_W;

    typedef enum logic [2:0] {
        IDLE,
        INSERT,
        LOOK1,
        LOOK2,
        INVAL
    } vc_state_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [WAY_W-1:0] lowest_way(input logic [NUM_WAYS-1:0] vec);
        logic [WAY_W-1:0] w;
        w = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (vec[i]) w = WAY_W'(i);
        end
        return w;
    endfunction

endpackage

// File: rtl/victim_cache_ctrl_if.sv
// Request/response and datapath control bundle of the victim cache controller.
// master: L1 + datapath side, slave: the controller.
interface victim_cache_ctrl_if;
    import vc_pkg::*;

    logic                evict_valid;
    logic                evict_ready;
    logic                lookup_valid;
    logic [ADDR_W-1:0]   lookup_addr;
    logic                lookup_ready;
    logic                tlb_miss;
    logic [NUM_WAYS-1:0] valid_bits;
    logic [NUM_WAYS-1:0] hit_vec;
    logic [NUM_WAYS-1:0] vc_write_en;
    logic [NUM_WAYS-1:0] vc_inval;
    logic [ADDR_W-1:0]   vc_addr;
    logic                rd_squash;
    logic                resp_valid;
    logic                resp_hit;
    logic [WAY_W-1:0]    resp_way;

    modport master (
        output evict_valid, lookup_valid, lookup_addr, tlb_miss, valid_bits, hit_vec,
        input  evict_ready, lookup_ready, vc_write_en, vc_inval, vc_addr,
               rd_squash, resp_valid, resp_hit, resp_way
    );

    modport slave (
        input  evict_valid, lookup_valid, lookup_addr, tlb_miss, valid_bits, hit_vec,
        output evict_ready, lookup_ready, vc_write_en, vc_inval, vc_addr,
               rd_squash, resp_valid, resp_hit, resp_way
    );

endinterface

// File: rtl/vc_plru.sv
// 7-bit tree pseudo-LRU for 8 ways. b[0] is the root, b[1..2] the middle
// level, b[3..6] the leaves; a bit of 0 steers the victim walk left.
// A touch either points the path away from the way (normal use) or toward
// it (so the next replacement picks that way).
module vc_plru
    import vc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             touch,
    input  logic             toward,
    input  logic [WAY_W-1:0] way,
    output logic [WAY_W-1:0] victim
);

    logic [PLRU_W-1:0] bits_q;
    logic [PLRU_W-1:0] bits_d;
    logic [WAY_W-1:0]  dir;

    // Walk the tree from the root to find the replacement way.
    always_comb begin
        victim    = '0;
        victim[2] = bits_q[0];
        victim[1] = victim[2] ? bits_q[2] : bits_q[1];
        case (victim[2:1])
            2'b00:   victim[0] = bits_q[3];
            2'b01:   victim[0] = bits_q[4];
            2'b10:   victim[0] = bits_q[5];
            default: victim[0] = bits_q[6];
        endcase
    end

    // Rewrite the three bits on the path of the touched way.
    always_comb begin
        bits_d = bits_q;
        dir    = way ^ {WAY_W{~toward}};
        if (touch) begin
            bits_d[0] = dir[2];
            if (way[2]) bits_d[2] = dir[1];
            else        bits_d[1] = dir[1];
            case (way[2:1])
                2'b00:   bits_d[3] = dir[0];
                2'b01:   bits_d[4] = dir[0];
                2'b10:   bits_d[5] = dir[0];
                default: bits_d[6] = dir[0];
            endcase
        end
    end

    // Tree state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) bits_q <= '0;
        else        bits_q <= bits_d;
    end

endmodule

// File: rtl/victim_cache_ctrl.sv
// Sequencing controller for the 8-entry fully associative victim cache.
// Arbitrates L1 eviction inserts against L1 miss lookups (inserts win),
// picks the replacement way, tracks the 2-cycle read and invalidates a
// hitting way as its line moves back to L1.
// Optional: define VC_PERF_CNT_EN to add saturating hit/miss/insert
// counters on perf_cnt = {inserts, misses, hits}.
module victim_cache_ctrl
    import vc_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    victim_cache_ctrl_if.slave bus,
    output logic               busy
`ifdef VC_PERF_CNT_EN
    ,
    output logic [95:0]        perf_cnt
`endif
);

    vc_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              tlb_q;
    logic [WAY_W-1:0]  way_q;
    logic [WAY_W-1:0]  victim, ins_way, plru_way, hit_way;
    logic              plru_touch, plru_toward;
    logic              evict_rdy, lookup_rdy;
    logic              hit_any;

    assign hit_any = |bus.hit_vec;
    assign hit_way = lowest_way(bus.hit_vec);
    // Fill an empty way first; only evict by PLRU when every way is valid.
    assign ins_way = (&bus.valid_bits) ? victim : lowest_way(~bus.valid_bits);

    vc_plru u_plru (
        .clk    (clk),
        .reset  (reset),
        .touch  (plru_touch),
        .toward (plru_toward),
        .way    (plru_way),
        .victim (victim)
    );

    // Next-state and per-state outputs.
    always_comb begin
        state_d         = state_q;
        evict_rdy       = 1'b0;
        lookup_rdy      = 1'b0;
        plru_touch      = 1'b0;
        plru_toward     = 1'b0;
        plru_way        = ins_way;
        bus.vc_write_en = '0;
        bus.vc_inval    = '0;
        bus.rd_squash   = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.resp_hit    = 1'b0;
        bus.resp_way    = '0;
        case (state_q)
            IDLE: begin
                evict_rdy  = bus.evict_valid;
                lookup_rdy = bus.lookup_valid && !bus.evict_valid;
                if (bus.evict_valid)       state_d = INSERT;
                else if (bus.lookup_valid) state_d = LOOK1;
            end
            INSERT: begin
                bus.vc_write_en = NUM_WAYS'(1) << ins_way;
                plru_touch      = 1'b1;
                state_d         = IDLE;
            end
            LOOK1: begin
                if (tlb_q) begin
                    bus.rd_squash  = 1'b1;
                    bus.resp_valid = 1'b1;
                    state_d        = IDLE;
                end else begin
                    state_d = LOOK2;
                end
            end
            LOOK2: begin
                bus.resp_valid = 1'b1;
                bus.resp_hit   = hit_any;
                bus.resp_way   = hit_way;
                state_d        = hit_any ? INVAL : IDLE;
            end
            INVAL: begin
                bus.vc_inval = NUM_WAYS'(1) << way_q;
                plru_touch   = 1'b1;
                plru_toward  = 1'b1;
                plru_way     = way_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Readies are held low while reset is asserted even though the state is IDLE.
    assign bus.evict_ready  = evict_rdy && reset;
    assign bus.lookup_ready = lookup_rdy && reset;
    assign bus.vc_addr      = addr_q;
    assign busy             = (state_q != IDLE);

    // State, latched lookup address/TLB status and the hitting way.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            tlb_q   <= 1'b0;
            way_q   <= '0;
        end else begin
            state_q <= state_d;
            if (lookup_rdy) begin
                addr_q <= bus.lookup_addr;
                tlb_q  <= bus.tlb_miss;
            end
            if (state_q == LOOK2) way_q <= hit_way;
        end
    end

`ifdef VC_PERF_CNT_EN
    logic [31:0] hits_q, misses_q, inserts_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    // Saturating event counters; squashed lookups count as misses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hits_q    <= '0;
            misses_q  <= '0;
            inserts_q <= '0;
        end else begin
            if (state_q == INSERT) inserts_q <= sat_inc(inserts_q);
            if (state_q == LOOK2 && hit_any) hits_q <= sat_inc(hits_q);
            if ((state_q == LOOK2 && !hit_any) || (state_q == LOOK1 && tlb_q))
                misses_q <= sat_inc(misses_q);
        end
    end

    assign perf_cnt = {inserts_q, misses_q, hits_q};
`endif

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Self-checking bench for victim_cache_ctrl. The bench plays L1 and the
// datapath (it owns the per-way valid bits) and keeps a reference model of
// the replacement tree as a plain bit array walked by node number.
module tb_victim_cache_ctrl;
    import vc_pkg::*;

    logic clk;
    logic reset;
    logic busy;
`ifdef VC_PERF_CNT_EN
    logic [95:0] perf_cnt;
`endif

    victim_cache_ctrl_if vif ();

    victim_cache_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif),
        .busy  (busy)
`ifdef VC_PERF_CNT_EN
        ,
        .perf_cnt (perf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model state
    bit [6:0] m_plru;
    bit [7:0] m_valid;
    int m_hits, m_misses, m_inserts;

    function automatic int m_victim();
        int node = 0;
        int w = 0;
        for (int l = 0; l < 3; l++) begin
            int d = int'(m_plru[node]);
            w = w * 2 + d;
            node = 2 * node + 1 + d;
        end
        return w;
    endfunction

    function automatic void m_set_path(int w, bit toward);
        int node = 0;
        for (int l = 2; l >= 0; l--) begin
            int d = (w >> l) & 1;
            m_plru[node] = toward ? d[0] : !d[0];
            node = 2 * node + 1 + d;
        end
    endfunction

    function automatic int m_insert_way();
        for (int i = 0; i < 8; i++) if (!m_valid[i]) return i;
        return m_victim();
    endfunction

    function automatic int m_first(bit [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (reset) assert ($onehot0(vif.hit_vec));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        vif.evict_valid = 0; vif.lookup_valid = 0; vif.tlb_miss = 0; vif.hit_vec = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        m_plru = '0; m_hits = 0; m_misses = 0; m_inserts = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        vif.evict_valid = 1; vif.lookup_valid = 1;
        #1;
        n_vec++;
        if ({vif.evict_ready, vif.lookup_ready, busy} !== 3'b000) begin
            n_err++; $display("FAIL reset_ctrl: got %b expected 000", {vif.evict_ready, vif.lookup_ready, busy});
        end
        n_vec++;
        if ({vif.vc_write_en, vif.vc_inval, vif.vc_addr, vif.rd_squash, vif.resp_valid, vif.resp_hit, vif.resp_way} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %h expected 0",
                {vif.vc_write_en, vif.vc_inval, vif.vc_addr, vif.rd_squash, vif.resp_valid, vif.resp_hit, vif.resp_way});
        end
        vif.evict_valid = 0; vif.lookup_valid = 0;
        @(negedge clk);
        reset = 1'b1;
        m_plru = '0; m_hits = 0; m_misses = 0; m_inserts = 0;
    endtask

    task automatic test_fill();
        apply_reset();
        m_valid = '0;
        for (int i = 0; i < 8; i++) begin
            int w;
            @(negedge clk);
            vif.valid_bits = m_valid; vif.evict_valid = 1;
            #1;
            n_vec++;
            if (vif.evict_ready !== 1'b1 || busy !== 1'b0) begin
                n_err++; $display("FAIL fill_accept[%0d]: ready=%b busy=%b expected 1 0", i, vif.evict_ready, busy);
            end
            @(negedge clk);
            vif.evict_valid = 0;
            #1;
            w = m_insert_way();
            n_vec++;
            if (vif.vc_write_en !== (8'h01 << i) || busy !== 1'b1) begin
                n_err++; $display("FAIL fill_we[%0d]: we=%h busy=%b expected %h 1", i, vif.vc_write_en, busy, 8'h01 << i);
            end
            m_set_path(w, 0); m_valid[w] = 1; m_inserts++;
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL fill_idle: busy=%b expected 0", busy); end
    endtask

    task automatic test_plru_full();
        bit [7:0] exp_we [2];
        exp_we[0] = 8'h01; exp_we[1] = 8'h10;
        apply_reset();
        m_valid = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            int w;
            @(negedge clk);
            vif.valid_bits = m_valid; vif.evict_valid = 1;
            @(negedge clk);
            vif.evict_valid = 0;
            #1;
            w = m_insert_way();
            n_vec++;
            if (vif.vc_write_en !== exp_we[k] || vif.vc_write_en !== 8'(1 << w)) begin
                n_err++; $display("FAIL plru_full[%0d]: got %h expected %h", k, vif.vc_write_en, exp_we[k]);
            end
            m_set_path(w, 0); m_valid[w] = 1; m_inserts++;
        end
    endtask

    task automatic test_lookup_hit();
        int w;
        @(negedge clk);
        vif.valid_bits = m_valid;
        vif.lookup_valid = 1; vif.lookup_addr = 12'hABC; vif.tlb_miss = 0;
        #1;
        n_vec++;
        if (vif.lookup_ready !== 1'b1) begin n_err++; $display("FAIL hit_accept: ready=%b expected 1", vif.lookup_ready); end
        @(negedge clk);
        vif.lookup_valid = 0; vif.lookup_addr = 12'h000;
        #1;
        n_vec++;
        if (vif.vc_addr !== 12'hABC || vif.resp_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL hit_look1: addr=%h rv=%b busy=%b expected abc 0 1", vif.vc_addr, vif.resp_valid, busy);
        end
        @(negedge clk);
        vif.hit_vec = 8'h20;
        #1;
        n_vec++;
        if ({vif.resp_valid, vif.resp_hit, vif.resp_way} !== {1'b1, 1'b1, 3'd5}) begin
            n_err++; $display("FAIL hit_resp: got %b expected 1_1_101", {vif.resp_valid, vif.resp_hit, vif.resp_way});
        end
        @(negedge clk);
        vif.hit_vec = 0;
        #1;
        n_vec++;
        if (vif.vc_inval !== 8'h20 || vif.vc_write_en !== 8'h00 || vif.resp_valid !== 1'b0) begin
            n_err++; $display("FAIL hit_inval: inval=%h we=%h rv=%b expected 20 00 0", vif.vc_inval, vif.vc_write_en, vif.resp_valid);
        end
        m_set_path(5, 1); m_valid[5] = 0; m_hits++;
        // The refill after the line leaves must land in the freed way.
        @(negedge clk);
        vif.valid_bits = m_valid; vif.evict_valid = 1;
        @(negedge clk);
        vif.evict_valid = 0;
        #1;
        w = m_insert_way();
        n_vec++;
        if (vif.vc_write_en !== 8'(1 << w)) begin
            n_err++; $display("FAIL hit_refill: got %h expected %h", vif.vc_write_en, 8'(1 << w));
        end
        m_set_path(w, 0); m_valid[w] = 1; m_inserts++;
    endtask

    task automatic test_tlb_squash();
        logic [11:0] a;
        a = 12'($urandom);
        @(negedge clk);
        vif.lookup_valid = 1; vif.lookup_addr = a; vif.tlb_miss = 1;
        @(negedge clk);
        vif.lookup_valid = 0; vif.tlb_miss = 0;
        #1;
        n_vec++;
        if ({vif.rd_squash, vif.resp_valid, vif.resp_hit} !== 3'b110 || vif.vc_addr !== a) begin
            n_err++; $display("FAIL squash_look1: got %b addr=%h expected 110 addr=%h",
                {vif.rd_squash, vif.resp_valid, vif.resp_hit}, vif.vc_addr, a);
        end
        m_misses++;
        @(negedge clk);
        #1;
        n_vec++;
        if ({busy, vif.resp_valid, vif.rd_squash} !== 3'b000 || vif.vc_inval !== 8'h00) begin
            n_err++; $display("FAIL squash_after: busy/rv/sq=%b inval=%h expected 000 00",
                {busy, vif.resp_valid, vif.rd_squash}, vif.vc_inval);
        end
    endtask

    task automatic test_priority();
        int w;
        @(negedge clk);
        vif.valid_bits = m_valid;
        vif.evict_valid = 1; vif.lookup_valid = 1; vif.lookup_addr = 12'h5A5; vif.tlb_miss = 0;
        #1;
        n_vec++;
        if ({vif.evict_ready, vif.lookup_ready} !== 2'b10) begin
            n_err++; $display("FAIL prio_idle: got %b expected 10", {vif.evict_ready, vif.lookup_ready});
        end
        @(negedge clk);
        vif.evict_valid = 0;
        #1;
        w = m_insert_way();
        n_vec++;
        if (vif.lookup_ready !== 1'b0 || vif.vc_write_en !== 8'(1 << w)) begin
            n_err++; $display("FAIL prio_insert: lrdy=%b we=%h expected 0 %h", vif.lookup_ready, vif.vc_write_en, 8'(1 << w));
        end
        m_set_path(w, 0); m_valid[w] = 1; m_inserts++;
        @(negedge clk);
        vif.valid_bits = m_valid;
        #1;
        n_vec++;
        if (vif.lookup_ready !== 1'b1) begin n_err++; $display("FAIL prio_lookup: lrdy=%b expected 1", vif.lookup_ready); end
        @(negedge clk);
        vif.lookup_valid = 0;
        @(negedge clk);
        vif.hit_vec = 0;
        #1;
        n_vec++;
        if ({vif.resp_valid, vif.resp_hit} !== 2'b10 || vif.vc_addr !== 12'h5A5) begin
            n_err++; $display("FAIL prio_resp: got %b addr=%h expected 10 addr=5a5", {vif.resp_valid, vif.resp_hit}, vif.vc_addr);
        end
        m_misses++;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            int kind;
            kind = $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0) m_valid = 8'($urandom);
            @(negedge clk);
            vif.valid_bits = m_valid;
            #1;
            n_vec++;
            if (busy !== 1'b0) begin n_err++; $display("FAIL rnd_idle[%0d]: busy=%b expected 0", n, busy); end
            if (kind == 0) begin
                int w;
                vif.evict_valid = 1;
                @(negedge clk);
                vif.evict_valid = 0;
                #1;
                w = m_insert_way();
                n_vec++;
                if (vif.vc_write_en !== 8'(1 << w) || vif.vc_inval !== 8'h00 || vif.evict_ready !== 1'b0) begin
                    n_err++; $display("FAIL rnd_insert[%0d]: we=%h inval=%h rdy=%b expected %h 00 0",
                        n, vif.vc_write_en, vif.vc_inval, vif.evict_ready, 8'(1 << w));
                end
                m_set_path(w, 0); m_valid[w] = 1; m_inserts++;
            end else begin
                logic [11:0] a;
                bit t;
                bit [7:0] hv;
                int w;
                a = 12'($urandom);
                t = (kind == 2);
                hv = 0;
                if (m_valid != 0 && $urandom_range(0, 2) != 0) begin
                    do w = $urandom_range(0, 7); while (!m_valid[w]);
                    hv[w] = 1'b1;
                end
                vif.lookup_valid = 1; vif.lookup_addr = a; vif.tlb_miss = t;
                @(negedge clk);
                vif.lookup_valid = 0; vif.tlb_miss = 1'($urandom); vif.lookup_addr = 12'($urandom);
                #1;
                n_vec++;
                if (vif.vc_addr !== a || vif.rd_squash !== t || vif.resp_valid !== t || vif.resp_hit !== 1'b0) begin
                    n_err++; $display("FAIL rnd_look1[%0d]: addr=%h sq=%b rv=%b rh=%b expected %h %b %b 0",
                        n, vif.vc_addr, vif.rd_squash, vif.resp_valid, vif.resp_hit, a, t, t);
                end
                if (t) begin
                    m_misses++;
                end else begin
                    @(negedge clk);
                    vif.hit_vec = hv;
                    #1;
                    w = m_first(hv);
                    n_vec++;
                    if (vif.resp_valid !== 1'b1 || vif.resp_hit !== (hv != 0) || vif.resp_way !== 3'(w)) begin
                        n_err++; $display("FAIL rnd_look2[%0d]: rv=%b rh=%b way=%0d expected 1 %b %0d",
                            n, vif.resp_valid, vif.resp_hit, vif.resp_way, (hv != 0), w);
                    end
                    if (hv != 0) begin
                        m_hits++;
                        @(negedge clk);
                        vif.hit_vec = 0;
                        #1;
                        n_vec++;
                        if (vif.vc_inval !== hv || vif.vc_write_en !== 8'h00) begin
                            n_err++; $display("FAIL rnd_inval[%0d]: inval=%h we=%h expected %h 00", n, vif.vc_inval, vif.vc_write_en, hv);
                        end
                        m_set_path(w, 1); m_valid[w] = 0;
                    end else begin
                        m_misses++;
                    end
                end
                vif.tlb_miss = 0;
                vif.hit_vec = 0;
            end
        end
        @(negedge clk);
`ifdef VC_PERF_CNT_EN
        n_vec++;
        if (perf_cnt !== {32'(m_inserts), 32'(m_misses), 32'(m_hits)}) begin
            n_err++; $display("FAIL perf_cnt: got %h expected %h", perf_cnt, {32'(m_inserts), 32'(m_misses), 32'(m_hits)});
        end
`endif
    endtask

    task automatic test_reset_mid();
        m_valid = 8'hFF;
        @(negedge clk);
        vif.valid_bits = m_valid;
        vif.lookup_valid = 1; vif.lookup_addr = 12'h3C3; vif.tlb_miss = 0;
        @(negedge clk);
        vif.lookup_valid = 0;
        @(negedge clk);
        vif.hit_vec = 8'h04;
        #1;
        reset = 1'b0;
        #1;
        n_vec++;
        if ({busy, vif.resp_valid, vif.resp_hit, vif.rd_squash} !== 4'b0000 || vif.vc_addr !== 12'h000 || vif.resp_way !== 3'd0) begin
            n_err++; $display("FAIL mid_reset: busy/rv/rh/sq=%b addr=%h way=%0d expected 0000 000 0",
                {busy, vif.resp_valid, vif.resp_hit, vif.rd_squash}, vif.vc_addr, vif.resp_way);
        end
`ifdef VC_PERF_CNT_EN
        n_vec++;
        if (perf_cnt !== 96'd0) begin n_err++; $display("FAIL mid_reset_perf: got %h expected 0", perf_cnt); end
`endif
        vif.hit_vec = 0;
        @(negedge clk);
        reset = 1'b1;
        m_plru = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if ({busy, vif.resp_valid} !== 2'b00 || vif.vc_inval !== 8'h00) begin
                n_err++; $display("FAIL mid_reset_after[%0d]: busy/rv=%b inval=%h expected 00 00", k, {busy, vif.resp_valid}, vif.vc_inval);
            end
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1;
        vif.evict_valid = 0; vif.lookup_valid = 0; vif.lookup_addr = 0;
        vif.tlb_miss = 0; vif.valid_bits = 0; vif.hit_vec = 0;
        m_valid = 0; m_plru = 0;
        test_reset();
        test_fill();
        test_plru_full();
        test_lookup_hit();
        test_tlb_squash();
        test_priority();
        apply_reset();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/victim_cache_ctrl.md
Name: victim_cache_ctrl

Overview:
- Sequencing controller for the 8-entry fully associative victim cache datapath.
- Arbitrates between two requesters:
  - L1 eviction inserts, which write a block into the victim cache.
  - L1 miss lookups, which run the 2-cycle byte-select then tag-compare read.
- Chooses the replacement way with tree pseudo-LRU and drives the datapath's one-hot write enables.
- Tracks the read pipeline, squashing it on TLB miss, and invalidates a way whose line moves back to L1.

Parameters:
- NUM_WAYS, 8, victim entries; power of 2, fixed to 8 for the 7-bit PLRU tree.
- TAG_W, 44, physical tag width.
- IDX_W, 6, index bits stored per entry.
- OFF_W, 6, byte offset width within a 512-bit block.

Ports:
- clk, in, 1: clock; all state changes on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- evict_valid, in, 1: L1 presents a victim block to insert.
- evict_ready, out, 1: insert accepted this cycle.
- lookup_valid, in, 1: L1 miss requests a victim cache lookup.
- lookup_addr, in, IDX_W+OFF_W: non-tag address bits of the lookup.
- lookup_ready, out, 1: lookup accepted this cycle.
- tlb_miss, in, 1: TLB miss for the accepted lookup; valid in the acceptance cycle.
- valid_bits, in, NUM_WAYS: per-way valid bits from the datapath.
- hit_vec, in, NUM_WAYS: per-way tag+index+valid match from datapath cycle 2.
- vc_write_en, out, NUM_WAYS: one-hot datapath write enable; the block is written with valid=1.
- vc_inval, out, NUM_WAYS: one-hot valid clear.
- vc_addr, out, IDX_W+OFF_W: registered lookup address driven to the datapath.
- rd_squash, out, 1: squashes the datapath pipeline registers.
- resp_valid, out, 1: lookup result valid (1 cycle).
- resp_hit, out, 1: lookup hit.
- resp_way, out, 3: way that hit.
- busy, out, 1: FSM not in IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM returns to IDLE; PLRU bits go to 0.
  - All outputs go to 0; evict_ready and lookup_ready go to 0.
  - Reset mid-lookup drops the lookup with no response.
- FSM states and transitions:
  - IDLE: evict_valid takes priority → INSERT. Otherwise lookup_valid → LOOK1.
  - Readies are combinational in IDLE: evict_ready=evict_valid; lookup_ready=lookup_valid&&!evict_valid.
  - INSERT (1 cycle):
    - Assert vc_write_en[w]; update PLRU to mark w most recently used; → IDLE.
    - w = lowest-index way with valid_bits=0; if all valid, w = PLRU victim.
  - LOOK1:
    - vc_addr holds the address latched at acceptance.
    - If tlb_miss was 1 in the acceptance cycle: rd_squash=1, resp_valid=1 and resp_hit=0 in LOOK1, → IDLE.
    - Otherwise → LOOK2.
  - LOOK2:
    - Sample hit_vec and assert resp_valid=1.
    - resp_hit = |hit_vec; resp_way = encoded way.
    - On hit → INVAL; on miss → IDLE.
  - INVAL (1 cycle):
    - Assert vc_inval[resp_way]; the line moves to L1.
    - PLRU points toward that way so the follow-on eviction refills it; → IDLE.
- Latency:
  - Lookup: response 2 cycles after acceptance; 1 cycle on a TLB-miss squash.
  - Insert: write visible to the datapath on the cycle after INSERT.
- hit_vec multi-hot is illegal. The bench asserts onehot0; RTL resolves it to the lowest way.
- vc_write_en and vc_inval are never asserted in the same cycle.
- Throughput: one operation in flight. Readies are 0 whenever busy=1.
- PLRU:
  - Bits b[0] root, b[1..2], b[3..6].
  - Victim walk: follow b=0 to the left, b=1 to the right.
  - Touch sets the path bits to point away from the touched way.

Optional Feature:
- Macro VC_PERF_CNT_EN.
- Defined: adds three 32-bit saturating counters (hits, misses incl. squashes, inserts) and output perf_cnt[95:0] as {inserts,misses,hits}. Counters clear on reset.
- Undefined: no counters and no perf_cnt port.

Decomposition:
- Shared package vc_pkg holds:
  - State enum vc_state_t {IDLE,INSERT,LOOK1,LOOK2,INVAL}.
  - Constants NUM_WAYS, TAG_W, IDX_W, OFF_W, PLRU_W=7.
- One sub-module, vc_plru: 7-bit tree state, touch input and way, victim output.

Test Plan:
- Reset then 8 inserts into an empty cache → vc_write_en = 0x01,0x02,…,0x80 in order; busy high 1 cycle each.
- All ways valid, PLRU=0 after reset, insert → vc_write_en=0x01. Second insert → 0x10.
- Lookup addr 0xABC, hit_vec=0x20 in LOOK2 → resp_valid=1, resp_hit=1, resp_way=5 two cycles after acceptance. Next cycle vc_inval=0x20.
- Lookup with tlb_miss=1 at acceptance → rd_squash=1 and resp_valid=1/resp_hit=0 one cycle later; no vc_inval.
- evict_valid and lookup_valid both high in IDLE → evict_ready=1, lookup_ready=0. The lookup is accepted the cycle after INSERT.
- reset pulsed low during LOOK2 → outputs 0 immediately; FSM in IDLE with no resp_valid. With VC_PERF_CNT_EN, counters read 0.
